free_list: RTL

- Circular FIFO of free physical register indices for the out-of-order RV32I core.
- Rename/dispatch dequeues one free preg per instruction that writes rd.
- Commit, the retire side of the ROB head, enqueues the previous preg mapping of the retiring rd.
- On a mispredict flush, every preg allocated by squashed instructions is returned in one cycle by pointer restore.

---
 rtl/rv32i_types.sv | 16 +
 rtl/free_list.sv | 80 ++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// Shared core types: physical/architectural register sizing and preg index.
// Free-list geometry is derived here so rename-side users agree on widths.
package rv32i_types;

   localparam int NUM_PREGS = 64;
   localparam int NUM_AREGS = 32;
   localparam int PREG_W    = $clog2(NUM_PREGS);
   localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
   localparam int FL_PTR_W  = $clog2(FL_DEPTH);
   localparam int FL_CNT_W  = FL_PTR_W + 1;

   typedef logic [PREG_W-1:0]   preg_t;
   typedef logic [FL_PTR_W-1:0] fl_ptr_t;
   typedef logic [FL_CNT_W-1:0] fl_cnt_t;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical register indices for rename.
// Flush rewinds head onto tail, reclaiming every in-flight allocation at once.
module free_list
   import rv32i_types::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    deq_i,
   output preg_t   deq_preg_o,
   output logic    deq_valid_o,
   input  logic    enq_i,
   input  preg_t   enq_preg_i,
   input  logic    flush_i,
   output fl_cnt_t count_o,
   output logic    full_o
);

   localparam fl_cnt_t CNT_FULL = fl_cnt_t'(FL_DEPTH);

   preg_t   mem_q [FL_DEPTH];
   preg_t   mem_d [FL_DEPTH];
   fl_ptr_t head_q, head_d;
   fl_ptr_t tail_q, tail_d;
   fl_cnt_t count_q, count_d;

   logic deq_acc;
   logic enq_acc;

   assign deq_valid_o = (count_q != '0);
   assign full_o      = (count_q == CNT_FULL);
   assign count_o     = count_q;
   assign deq_preg_o  = mem_q[head_q];

   assign deq_acc = deq_i && deq_valid_o && !flush_i;
   assign enq_acc = enq_i && (enq_preg_i != '0) && !full_o;

   always_comb begin
      mem_d = mem_q;
      if (enq_acc) begin
         mem_d[tail_q] = enq_preg_i;
      end
   end

   // Free entries sit in [head, tail); allocations still in flight in [tail, head).
   always_comb begin
      tail_d  = tail_q + fl_ptr_t'(enq_acc);
      head_d  = head_q + fl_ptr_t'(deq_acc);
      count_d = count_q + fl_cnt_t'(enq_acc) - fl_cnt_t'(deq_acc);
      if (flush_i) begin
         head_d  = tail_d;
         count_d = CNT_FULL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            mem_q[i] <= preg_t'(NUM_AREGS + i);
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CNT_FULL;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(deq_i && !deq_valid_o && !flush_i))
            else $warning("free_list: dequeue while empty ignored");
         assert (!(enq_i && (enq_preg_i != '0) && full_o))
            else $warning("free_list: enqueue while full dropped (double free)");
      end
   end

endmodule
